// File: rtl/fe_pkg.sv
// Front-end shared types: bus operand type plus GPIO register offsets and
// the decoded register index used by gpio_bank.
package fe_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;

  localparam logic [5:0] GPIO_OFS_DATA_IN    = 6'h00;
  localparam logic [5:0] GPIO_OFS_DATA_OUT   = 6'h04;
  localparam logic [5:0] GPIO_OFS_DIR        = 6'h08;
  localparam logic [5:0] GPIO_OFS_OUT_SET    = 6'h0C;
  localparam logic [5:0] GPIO_OFS_OUT_CLR    = 6'h10;
  localparam logic [5:0] GPIO_OFS_OUT_TGL    = 6'h14;
  localparam logic [5:0] GPIO_OFS_RISE_EN    = 6'h18;
  localparam logic [5:0] GPIO_OFS_FALL_EN    = 6'h1C;
  localparam logic [5:0] GPIO_OFS_IRQ_STATUS = 6'h20;

  typedef enum logic [3:0] {
    GPIO_REG_DATA_IN    = 4'd0,
    GPIO_REG_DATA_OUT   = 4'd1,
    GPIO_REG_DIR        = 4'd2,
    GPIO_REG_OUT_SET    = 4'd3,
    GPIO_REG_OUT_CLR    = 4'd4,
    GPIO_REG_OUT_TGL    = 4'd5,
    GPIO_REG_RISE_EN    = 4'd6,
    GPIO_REG_FALL_EN    = 4'd7,
    GPIO_REG_IRQ_STATUS = 4'd8,
    GPIO_REG_NONE       = 4'd15
  } gpio_reg_e;

  // Only word offsets inside the 64-byte window are meaningful.
  function automatic gpio_reg_e gpio_decode(input logic [5:0] ofs);
    case (ofs[5:2])
      GPIO_OFS_DATA_IN[5:2]:    return GPIO_REG_DATA_IN;
      GPIO_OFS_DATA_OUT[5:2]:   return GPIO_REG_DATA_OUT;
      GPIO_OFS_DIR[5:2]:        return GPIO_REG_DIR;
      GPIO_OFS_OUT_SET[5:2]:    return GPIO_REG_OUT_SET;
      GPIO_OFS_OUT_CLR[5:2]:    return GPIO_REG_OUT_CLR;
      GPIO_OFS_OUT_TGL[5:2]:    return GPIO_REG_OUT_TGL;
      GPIO_OFS_RISE_EN[5:2]:    return GPIO_REG_RISE_EN;
      GPIO_OFS_FALL_EN[5:2]:    return GPIO_REG_FALL_EN;
      GPIO_OFS_IRQ_STATUS[5:2]: return GPIO_REG_IRQ_STATUS;
      default:                  return GPIO_REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Vector multi-stage synchroniser with rise/fall detection on the final stage
// against a one-cycle-delayed copy.
module sync_edge_detect #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];
  assign rise = sync & ~prev_p;
  assign fall = ~sync & prev_p;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction/data registers with atomic set/clear/
// toggle, synchronised inputs and RW1C edge-interrupt status.
module gpio_bank
  import fe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gpio_sel,
  input  logic             gpio_wren,
  input  RV32I_OPERAND_t   bus_addr,
  input  logic [31:0]      gpio_wrdata,
  output logic [31:0]      gpio_rddata,
  input  logic [WIDTH-1:0] gpio_port_in,
  output logic [WIDTH-1:0] gpio_port_out,
  output logic [WIDTH-1:0] gpio_port_oe,
  output logic             gpio_irq
);

  logic [WIDTH-1:0] data_out, dir, rise_en, fall_en, irq_status;
  logic [WIDTH-1:0] pin_sync, pin_rise, pin_fall;
  logic [WIDTH-1:0] wr_val, status_clr, edge_hit, rd_val;
  logic             wr;
  gpio_reg_e        reg_idx;
  logic             unused_bits;

  sync_edge_detect #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (gpio_port_in),
    .sync     (pin_sync),
    .rise     (pin_rise),
    .fall     (pin_fall)
  );

  assign reg_idx     = gpio_decode(bus_addr[5:0]);
  assign wr          = gpio_sel & gpio_wren;
  assign wr_val      = gpio_wrdata[WIDTH-1:0];
  assign unused_bits = ^{bus_addr[31:6], bus_addr[1:0], gpio_wrdata};

  assign status_clr = (wr && reg_idx == GPIO_REG_IRQ_STATUS) ? wr_val : '0;
  assign edge_hit   = (pin_rise & rise_en) | (pin_fall & fall_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      dir        <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      irq_status <= '0;
    end else begin
      // Fresh edges are OR'd in after the clear so a coincident edge wins.
      irq_status <= (irq_status & ~status_clr) | edge_hit;
      if (wr) begin
        case (reg_idx)
          GPIO_REG_DATA_OUT: data_out <= wr_val;
          GPIO_REG_DIR:      dir      <= wr_val;
          GPIO_REG_OUT_SET:  data_out <= data_out | wr_val;
          GPIO_REG_OUT_CLR:  data_out <= data_out & ~wr_val;
          GPIO_REG_OUT_TGL:  data_out <= data_out ^ wr_val;
          GPIO_REG_RISE_EN:  rise_en  <= wr_val;
          GPIO_REG_FALL_EN:  fall_en  <= wr_val;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (gpio_sel) begin
      case (reg_idx)
        GPIO_REG_DATA_IN:    rd_val = pin_sync;
        GPIO_REG_DATA_OUT:   rd_val = data_out;
        GPIO_REG_DIR:        rd_val = dir;
        GPIO_REG_RISE_EN:    rd_val = rise_en;
        GPIO_REG_FALL_EN:    rd_val = fall_en;
        GPIO_REG_IRQ_STATUS: rd_val = irq_status;
        default:             rd_val = '0;
      endcase
    end
  end

  assign gpio_rddata   = 32'(rd_val);
  assign gpio_port_out = data_out;
  assign gpio_port_oe  = dir;
  assign gpio_irq      = |irq_status;

endmodule
